// File: rtl/hash_bridge_pkg.sv
// Shared types and helpers for the UART <-> hash core framing bridge.
package hash_bridge_pkg;

  // Bridge control states: collect, kick the hasher, wait, send byte, wait for UART.
  typedef enum logic [2:0] {
    S_RX    = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_TX    = 3'd3,
    S_TXW   = 3'd4
  } bridge_state_t;

  // Widest digest the byte selector accepts; narrower digests are zero-extended.
  localparam int unsigned MAX_DIGEST_BITS = 1024;

  // Returns byte number idx of the digest, counted from the least significant byte.
  function automatic logic [7:0] byte_sel(input logic [MAX_DIGEST_BITS-1:0] digest,
                                          input int unsigned idx);
    return 8'(digest >> (8 * idx));
  endfunction

endpackage

// File: rtl/uart_hash_bridge.sv
// Framing bridge: assembles a message from UART bytes, runs the hash core and
// streams the digest back to the UART transmitter MSB first.
module uart_hash_bridge
  import hash_bridge_pkg::*;
#(
  parameter int unsigned MSG_BYTES    = 1,
  parameter int unsigned DIGEST_BITS  = 256,
  parameter int unsigned TIMEOUT_CLKS = 52080
) (
  input  logic                     i_Clk,
  input  logic                     i_rst,
  input  logic                     i_rx_dv,
  input  logic [7:0]               i_rx_byte,
  output logic [8*MSG_BYTES-1:0]   o_msg,
  output logic                     o_hash_start,
  input  logic                     i_hash_done,
  input  logic [DIGEST_BITS-1:0]   i_digest,
  output logic                     o_tx_dv,
  output logic [7:0]               o_tx_byte,
  input  logic                     i_tx_active,
  input  logic                     i_tx_done,
  output logic                     o_busy,
  output logic                     o_frame_err,
  output logic [7:0]               o_drop_cnt
);

  localparam int unsigned DIGEST_BYTES = DIGEST_BITS / 8;
  localparam int unsigned RXC_W  = $clog2(MSG_BYTES + 1);
  localparam int unsigned TXC_W  = $clog2(DIGEST_BYTES + 1);
  localparam int unsigned IDLE_W = (TIMEOUT_CLKS == 0) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam bit          TIMEOUT_EN = (TIMEOUT_CLKS != 0);

  localparam logic [RXC_W-1:0]  RX_LAST   = RXC_W'(MSG_BYTES - 1);
  localparam logic [TXC_W-1:0]  TX_LAST   = TXC_W'(DIGEST_BYTES - 1);
  // The timeout fires on the idle cycle that brings the count to TIMEOUT_CLKS.
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CLKS == 0) ? 0 : TIMEOUT_CLKS - 1);

  bridge_state_t            state_reg, state_next;
  logic [RXC_W-1:0]         rx_cnt_reg, rx_cnt_next;
  logic [TXC_W-1:0]         tx_cnt_reg, tx_cnt_next;
  logic [IDLE_W-1:0]        idle_cnt_reg, idle_cnt_next;
  logic [DIGEST_BITS-1:0]   digest_reg, digest_next;
  logic                     hash_start_reg, hash_start_next;
  logic                     tx_dv_reg, tx_dv_next;
  logic [7:0]               tx_byte_reg, tx_byte_next;
  logic                     busy_reg, busy_next;
  logic                     frame_err_reg, frame_err_next;
  logic [7:0]               drop_cnt_reg, drop_cnt_next;
  logic                     store_byte;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_next      = state_reg;
    rx_cnt_next     = rx_cnt_reg;
    tx_cnt_next     = tx_cnt_reg;
    idle_cnt_next   = '0;
    digest_next     = digest_reg;
    hash_start_next = 1'b0;
    tx_dv_next      = 1'b0;
    tx_byte_next    = tx_byte_reg;
    frame_err_next  = 1'b0;
    drop_cnt_next   = drop_cnt_reg;
    store_byte      = 1'b0;

    case (state_reg)
      S_RX: begin
        if (i_rx_dv) begin
          // A byte arriving on the timeout cycle wins: stored, no error.
          store_byte = 1'b1;
          if (rx_cnt_reg == RX_LAST) begin
            rx_cnt_next = '0;
            state_next  = S_START;
          end else begin
            rx_cnt_next = rx_cnt_reg + 1'b1;
          end
        end else if (TIMEOUT_EN && rx_cnt_reg != '0) begin
          if (idle_cnt_reg == IDLE_LAST) begin
            // Discard the partial frame; already written bytes stay in o_msg.
            rx_cnt_next    = '0;
            frame_err_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
      end
      S_START: begin
        hash_start_next = 1'b1;
        state_next      = S_WAIT;
      end
      S_WAIT: begin
        if (i_hash_done) begin
          digest_next = i_digest;
          tx_cnt_next = '0;
          state_next  = S_TX;
        end
      end
      S_TX: begin
        if (!i_tx_active) begin
          tx_dv_next   = 1'b1;
          tx_byte_next = byte_sel(MAX_DIGEST_BITS'(digest_reg),
                                  DIGEST_BYTES - 1 - 32'(tx_cnt_reg));
          state_next   = S_TXW;
        end
      end
      S_TXW: begin
        if (i_tx_done) begin
          if (tx_cnt_reg == TX_LAST) begin
            state_next = S_RX;
          end else begin
            tx_cnt_next = tx_cnt_reg + 1'b1;
            state_next  = S_TX;
          end
        end
      end
      default: state_next = S_RX;
    endcase

    // Bytes offered while busy are counted, never stored.
    if (i_rx_dv && state_reg != S_RX && drop_cnt_reg != 8'hFF)
      drop_cnt_next = drop_cnt_reg + 8'd1;

    busy_next = (state_next != S_RX);
  end

  // State, counters and output registers.
  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_reg      <= S_RX;
      rx_cnt_reg     <= '0;
      tx_cnt_reg     <= '0;
      idle_cnt_reg   <= '0;
      digest_reg     <= '0;
      hash_start_reg <= 1'b0;
      tx_dv_reg      <= 1'b0;
      tx_byte_reg    <= '0;
      busy_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      rx_cnt_reg     <= rx_cnt_next;
      tx_cnt_reg     <= tx_cnt_next;
      idle_cnt_reg   <= idle_cnt_next;
      digest_reg     <= digest_next;
      hash_start_reg <= hash_start_next;
      tx_dv_reg      <= tx_dv_next;
      tx_byte_reg    <= tx_byte_next;
      busy_reg       <= busy_next;
      frame_err_reg  <= frame_err_next;
      drop_cnt_reg   <= drop_cnt_next;
    end
  end

  // One register per message byte; byte k lands in the k-th most significant slot.
  for (genvar gi = 0; gi < MSG_BYTES; gi++) begin : g_msg
    logic [7:0] msg_byte_reg;

    // Capture received byte gi when the write pointer selects it.
    always_ff @(posedge i_Clk) begin
      if (i_rst)
        msg_byte_reg <= '0;
      else if (store_byte && rx_cnt_reg == RXC_W'(gi))
        msg_byte_reg <= i_rx_byte;
    end

    assign o_msg[8*(MSG_BYTES-1-gi) +: 8] = msg_byte_reg;
  end

  assign o_hash_start = hash_start_reg;
  assign o_tx_dv      = tx_dv_reg;
  assign o_tx_byte    = tx_byte_reg;
  assign o_busy       = busy_reg;
  assign o_frame_err  = frame_err_reg;
  assign o_drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_uart_hash_bridge.sv
// Directed plus randomized bench for uart_hash_bridge (4-byte message, 32-bit digest).
module tb_uart_hash_bridge;

  localparam int MB = 4;
  localparam int DB = 32;
  localparam int TO = 100;

  logic          i_Clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_rx_dv = 1'b0;
  logic [7:0]    i_rx_byte = '0;
  logic [31:0]   o_msg;
  logic          o_hash_start;
  logic          i_hash_done = 1'b0;
  logic [31:0]   i_digest = '0;
  logic          o_tx_dv;
  logic [7:0]    o_tx_byte;
  logic          i_tx_active = 1'b0;
  logic          i_tx_done = 1'b0;
  logic          o_busy;
  logic          o_frame_err;
  logic [7:0]    o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int hs_seen = 0;
  int tx_seen = 0;
  int fe_seen = 0;
  int drops_model = 0;
  logic [31:0] last_msg = '0;

  uart_hash_bridge #(
    .MSG_BYTES(MB),
    .DIGEST_BITS(DB),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .i_Clk(i_Clk),
    .i_rst(i_rst),
    .i_rx_dv(i_rx_dv),
    .i_rx_byte(i_rx_byte),
    .o_msg(o_msg),
    .o_hash_start(o_hash_start),
    .i_hash_done(i_hash_done),
    .i_digest(i_digest),
    .o_tx_dv(o_tx_dv),
    .o_tx_byte(o_tx_byte),
    .i_tx_active(i_tx_active),
    .i_tx_done(i_tx_done),
    .o_busy(o_busy),
    .o_frame_err(o_frame_err),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_Clk = ~i_Clk;

  // Pulse counters sampled on the falling edge.
  always @(negedge i_Clk) begin
    if (o_hash_start) hs_seen++;
    if (o_tx_dv)      tx_seen++;
    if (o_frame_err)  fe_seen++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_dv   = 1'b1;
    i_rx_byte = b;
    tick();
    i_rx_dv   = 1'b0;
  endtask

  // Send the first n bytes of message m, most significant byte first.
  task automatic send_msg(input logic [31:0] m, input int n);
    for (int i = 0; i < n; i++) send_byte(8'(m >> (8 * (3 - i))));
  endtask

  // Digest byte k as transmitted: byte 0 is the most significant.
  function automatic logic [7:0] digest_byte(input logic [31:0] d, input int k);
    return 8'(d >> (8 * (3 - k)));
  endfunction

  task automatic check_reset_outputs();
    check("rst_msg",        64'(o_msg),        64'd0);
    check("rst_hash_start", 64'(o_hash_start), 64'd0);
    check("rst_tx_dv",      64'(o_tx_dv),      64'd0);
    check("rst_tx_byte",    64'(o_tx_byte),    64'd0);
    check("rst_busy",       64'(o_busy),       64'd0);
    check("rst_frame_err",  64'(o_frame_err),  64'd0);
    check("rst_drop_cnt",   64'(o_drop_cnt),   64'd0);
  endtask

  // Runs the rest of a frame, called right after the last message byte was strobed.
  task automatic complete_frame(input logic [31:0] exp_msg, input logic [31:0] dig,
                                input int n_drops, input int bp_cycles, input int n_bytes);
    int hs0;
    int tx0;
    hs0 = hs_seen;
    tx0 = tx_seen;
    check("start_early", 64'(o_hash_start), 64'd0);
    check("busy_rise",   64'(o_busy),       64'd1);
    tick();
    check("hash_start",  64'(o_hash_start), 64'd1);
    check("msg",         64'(o_msg),        64'(exp_msg));
    tick();
    check("start_width", 64'(o_hash_start), 64'd0);
    for (int i = 0; i < n_drops; i++) begin
      send_byte(8'($urandom));
      drops_model = (drops_model < 255) ? drops_model + 1 : 255;
      check("drop_cnt", 64'(o_drop_cnt), 64'(drops_model));
    end
    if (n_drops > 0) check("msg_after_drops", 64'(o_msg), 64'(exp_msg));
    repeat ($urandom_range(0, 4)) tick();
    i_hash_done = 1'b1;
    i_digest    = dig;
    i_tx_active = (bp_cycles > 0);
    tick();
    i_hash_done = 1'b0;
    i_digest    = 32'($urandom);
    check("tx_dv_early", 64'(o_tx_dv), 64'd0);
    for (int i = 0; i < bp_cycles; i++) begin
      tick();
      check("tx_dv_backpressure", 64'(o_tx_dv), 64'd0);
    end
    i_tx_active = 1'b0;
    tick();
    check("tx_dv_first", 64'(o_tx_dv), 64'd1);
    for (int k = 0; k < n_bytes; k++) begin
      check("tx_byte",    64'(o_tx_byte), 64'(digest_byte(dig, k)));
      check("msg_stable", 64'(o_msg),     64'(exp_msg));
      tick();
      check("tx_dv_width", 64'(o_tx_dv), 64'd0);
      if (k == n_bytes - 1 && n_bytes < 4) break;
      repeat ($urandom_range(0, 3)) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      if (k < 3) begin
        check("tx_dv_gap", 64'(o_tx_dv), 64'd0);
        check("busy_tx",   64'(o_busy),  64'd1);
        tick();
        check("tx_dv_next", 64'(o_tx_dv), 64'd1);
      end else begin
        check("busy_fall", 64'(o_busy), 64'd0);
      end
    end
    if (n_bytes == 4) begin
      tick();
      check("hash_start_pulses", 64'(hs_seen - hs0), 64'd1);
      check("tx_dv_pulses",      64'(tx_seen - tx0), 64'd4);
      last_msg = exp_msg;
    end
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] d;
    int fe0;
    int tx0;

    // Reset state
    i_rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs();
    i_rst = 1'b0;
    tick();
    $display("step reset: checks=%0d errors=%0d", checks, errors);

    // Normal frame
    send_msg(32'hDEADBEEF, 4);
    complete_frame(32'hDEADBEEF, 32'h01234567, 0, 0, 4);
    $display("step normal frame: checks=%0d errors=%0d", checks, errors);

    // Random frames
    for (int r = 0; r < 3; r++) begin
      m = $urandom;
      d = $urandom;
      repeat ($urandom_range(0, 3)) tick();
      send_msg(m, 4);
      complete_frame(m, d, 0, 0, 4);
      $display("step random frame %0d msg=%08h digest=%08h: checks=%0d errors=%0d",
               r, m, d, checks, errors);
    end

    // Timeout discards a partial frame
    fe0 = fe_seen;
    send_msg(32'h11220000, 2);
    repeat (TO - 1) tick();
    check("timeout_early", 64'(o_frame_err), 64'd0);
    tick();
    check("timeout_fire", 64'(o_frame_err), 64'd1);
    check("timeout_msg_kept", 64'(o_msg), 64'({8'h11, 8'h22, last_msg[15:0]}));
    tick();
    check("timeout_width", 64'(o_frame_err), 64'd0);
    send_msg(32'hA0A1A2A3, 3);
    check("timeout_no_start", 64'(hs_seen), 64'(hs_seen));
    check("timeout_busy", 64'(o_busy), 64'd0);
    send_byte(8'hA3);
    check("timeout_pulses", 64'(fe_seen - fe0), 64'd1);
    complete_frame(32'hA0A1A2A3, 32'($urandom), 0, 0, 4);
    $display("step timeout: checks=%0d errors=%0d", checks, errors);

    // Byte on the cycle the timeout would fire
    fe0 = fe_seen;
    send_msg(32'hB0B10000, 2);
    repeat (TO - 1) tick();
    check("boundary_no_err_pre", 64'(o_frame_err), 64'd0);
    send_byte(8'hB2);
    check("boundary_no_err", 64'(o_frame_err), 64'd0);
    send_byte(8'hB3);
    check("boundary_pulses", 64'(fe_seen - fe0), 64'd0);
    complete_frame(32'hB0B1B2B3, 32'($urandom), 0, 0, 4);
    $display("step boundary: checks=%0d errors=%0d", checks, errors);

    // Drops while busy, saturating at 255
    m = $urandom;
    send_msg(m, 4);
    complete_frame(m, 32'($urandom), 303, 0, 4);
    check("drop_saturated", 64'(o_drop_cnt), 64'd255);
    $display("step drops: checks=%0d errors=%0d", checks, errors);

    // Transmitter backpressure
    m = $urandom;
    send_msg(m, 4);
    complete_frame(m, 32'($urandom), 0, 50, 4);
    $display("step backpressure: checks=%0d errors=%0d", checks, errors);

    // Reset after the second digest byte
    m = $urandom;
    send_msg(m, 4);
    complete_frame(m, 32'($urandom), 0, 0, 2);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_reset_outputs();
    drops_model = 0;
    last_msg = '0;
    tx0 = tx_seen;
    for (int i = 0; i < 20; i++) begin
      i_tx_done   = (i % 3 == 0);
      i_hash_done = (i % 5 == 0);
      tick();
    end
    i_tx_done   = 1'b0;
    i_hash_done = 1'b0;
    tick();
    check("post_reset_no_tx", 64'(tx_seen - tx0), 64'd0);
    check("post_reset_idle",  64'(o_busy),        64'd0);
    m = $urandom;
    send_msg(m, 4);
    complete_frame(m, 32'($urandom), 0, 0, 4);
    $display("step reset mid-transmit: checks=%0d errors=%0d", checks, errors);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
